// File: rtl/aclk_multi_alarm_controller.sv
// ---------------------------------------------------------------------------
// aclk_multi_alarm_controller
// Keypad entry sequencer for the alarm clock. It collects MAX_DIGITS key
// presses, commits them to the current time or to one of N_ALARMS alarm
// slots, shows the selected alarm, and abandons an entry that is incomplete
// or idle for TIMEOUT_S seconds.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   one_second     one-cycle pulse per second (inactivity timer tick)
//   alarm_button   show alarm / commit entry to alarm slot
//   time_button    commit entry to current time
//   key            keypad code, NOKEY when idle
//   alarm_sel      requested alarm slot
//   reset_count    clear seconds counter (with load_new_c)
//   load_new_c     load key buffer into current time
//   show_new_time  display key buffer
//   show_a         display alarm alarm_idx
//   load_new_a     one-hot alarm slot load strobe
//   shift          shift key into key buffer
//   alarm_idx      latched alarm slot
//   digit_count    digits accepted in the current entry
//   entry_abort    one-cycle pulse when an entry is discarded
//
// state            | meaning
// SHOW_TIME        | idle, showing current time
// KEY_STORED       | shift the pressed key into the buffer
// KEY_WAITED       | waiting for key release
// KEY_ENTRY        | entry in progress, waiting for next key or button
// SHOW_ALARM       | alarm_button held, showing alarm alarm_idx
// SET_ALARM_TIME   | load buffer into alarm slot alarm_idx
// SET_CURRENT_TIME | load buffer into current time
// ENTRY_ABORT      | entry discarded
// ---------------------------------------------------------------------------
module aclk_multi_alarm_controller #(
  parameter int         N_ALARMS   = 2,
  parameter int         SEL_W      = 1,
  parameter int         TIMEOUT_S  = 10,
  parameter int         MAX_DIGITS = 4,
  parameter logic [3:0] NOKEY      = 4'd10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                one_second,
  input  logic                alarm_button,
  input  logic                time_button,
  input  logic [3:0]          key,
  input  logic [SEL_W-1:0]    alarm_sel,
  output logic                reset_count,
  output logic                load_new_c,
  output logic                show_new_time,
  output logic                show_a,
  output logic [N_ALARMS-1:0] load_new_a,
  output logic                shift,
  output logic [SEL_W-1:0]    alarm_idx,
  output logic [2:0]          digit_count,
  output logic                entry_abort
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6,
    ENTRY_ABORT      = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_timer;
  logic [2:0]       r_digit_count;
  logic [SEL_W-1:0] r_alarm_idx;
  logic             w_latch_idx;
  logic             w_complete;
  logic             w_timeout;
  logic             w_in_entry;
  logic             w_key_down;
  logic             w_sel_ok;

  assign w_complete = (r_digit_count == 3'(MAX_DIGITS));
  assign w_in_entry = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);
  assign w_timeout  = w_in_entry && (r_timer == 8'(TIMEOUT_S));
  assign w_key_down = (key != NOKEY);
  // Slot requests beyond the implemented alarms fall back to slot 0.
  assign w_sel_ok   = (32'(alarm_sel) < 32'(N_ALARMS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SHOW_TIME;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_latch_idx   = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    show_a        = 1'b0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    entry_abort   = 1'b0;
    load_new_a    = '0;

    case (r_state)
      SHOW_TIME: begin
        if (alarm_button) begin
          w_next      = SHOW_ALARM;
          w_latch_idx = 1'b1;
        end else if (w_key_down) begin
          w_next = KEY_STORED;
        end
      end
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!w_key_down)    w_next = KEY_ENTRY;
        else if (w_timeout) w_next = ENTRY_ABORT;
      end
      KEY_ENTRY: begin
        // Buttons outrank the timeout; alarm outranks time.
        if (alarm_button) begin
          w_next      = w_complete ? SET_ALARM_TIME : ENTRY_ABORT;
          w_latch_idx = w_complete;
        end else if (time_button) begin
          w_next = w_complete ? SET_CURRENT_TIME : ENTRY_ABORT;
        end else if (w_timeout) begin
          w_next = ENTRY_ABORT;
        end else if (w_key_down && !w_complete) begin
          w_next = KEY_STORED;
        end
      end
      SHOW_ALARM: if (!alarm_button) w_next = SHOW_TIME;
      default:    w_next = SHOW_TIME;
    endcase

    show_new_time = (r_state == KEY_STORED) || w_in_entry;
    shift         = (r_state == KEY_STORED);
    show_a        = (r_state == SHOW_ALARM);
    load_new_c    = (r_state == SET_CURRENT_TIME);
    reset_count   = (r_state == SET_CURRENT_TIME);
    entry_abort   = (r_state == ENTRY_ABORT);
    for (int i = 0; i < N_ALARMS; i++)
      load_new_a[i] = (r_state == SET_ALARM_TIME) && (32'(r_alarm_idx) == 32'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer       <= '0;
      r_digit_count <= '0;
      r_alarm_idx   <= '0;
    end else begin
      if (w_latch_idx)
        r_alarm_idx <= w_sel_ok ? alarm_sel : '0;

      if (w_next == SHOW_TIME)
        r_digit_count <= '0;
      else if ((r_state == KEY_STORED) && !w_complete)
        r_digit_count <= r_digit_count + 3'd1;

      // Restart on every entry edge so a pulse coinciding with it is dropped.
      // The timer never passes TIMEOUT_S: reaching it always forces an exit.
      if (!w_in_entry || (w_next != r_state))
        r_timer <= '0;
      else if (one_second)
        r_timer <= r_timer + 8'd1;
    end
  end

  assign digit_count = r_digit_count;
  assign alarm_idx   = r_alarm_idx;

endmodule

// File: tb/tb_aclk_multi_alarm_controller.sv
module tb_aclk_multi_alarm_controller;

  localparam int         N_ALARMS   = 4;
  localparam int         SEL_W      = 2;
  localparam int         TIMEOUT_S  = 3;
  localparam int         MAX_DIGITS = 4;
  localparam logic [3:0] NOKEY      = 4'd10;

  logic                clk = 1'b0;
  logic                rst;
  logic                one_second;
  logic                alarm_button;
  logic                time_button;
  logic [3:0]          key;
  logic [SEL_W-1:0]    alarm_sel;
  logic                reset_count;
  logic                load_new_c;
  logic                show_new_time;
  logic                show_a;
  logic [N_ALARMS-1:0] load_new_a;
  logic                shift;
  logic [SEL_W-1:0]    alarm_idx;
  logic [2:0]          digit_count;
  logic                entry_abort;

  int total = 0;
  int bad   = 0;

  aclk_multi_alarm_controller #(
    .N_ALARMS(N_ALARMS), .SEL_W(SEL_W), .TIMEOUT_S(TIMEOUT_S),
    .MAX_DIGITS(MAX_DIGITS), .NOKEY(NOKEY)
  ) dut (
    .clk(clk), .rst(rst), .one_second(one_second),
    .alarm_button(alarm_button), .time_button(time_button), .key(key),
    .alarm_sel(alarm_sel), .reset_count(reset_count), .load_new_c(load_new_c),
    .show_new_time(show_new_time), .show_a(show_a), .load_new_a(load_new_a),
    .shift(shift), .alarm_idx(alarm_idx), .digit_count(digit_count),
    .entry_abort(entry_abort)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the user is currently doing.
  localparam int IDLE = 0, SHIFTING = 1, RELEASE = 2, TYPING = 3,
                 VIEW_ALARM = 4, COMMIT_ALARM = 5, COMMIT_TIME = 6, DISCARD = 7;

  int m_ph;
  int m_digits;
  int m_idx;
  int m_secs;

  function automatic int sel_clip();
    return (int'(alarm_sel) < N_ALARMS) ? int'(alarm_sel) : 0;
  endfunction

  function automatic bit busy(int ph);
    return (ph == RELEASE) || (ph == TYPING);
  endfunction

  function automatic int next_phase();
    bit full;
    bit late;
    full = (m_digits == MAX_DIGITS);
    late = busy(m_ph) && (m_secs == TIMEOUT_S);
    case (m_ph)
      IDLE:       return alarm_button ? VIEW_ALARM : (key != NOKEY) ? SHIFTING : IDLE;
      SHIFTING:   return RELEASE;
      RELEASE:    return (key == NOKEY) ? TYPING : late ? DISCARD : RELEASE;
      TYPING: begin
        if (alarm_button) return full ? COMMIT_ALARM : DISCARD;
        if (time_button)  return full ? COMMIT_TIME : DISCARD;
        if (late)         return DISCARD;
        if (key != NOKEY && !full) return SHIFTING;
        return TYPING;
      end
      VIEW_ALARM: return alarm_button ? VIEW_ALARM : IDLE;
      default:    return IDLE;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph     <= IDLE;
      m_digits <= 0;
      m_idx    <= 0;
      m_secs   <= 0;
    end else begin
      m_ph <= next_phase();
      if ((m_ph == IDLE && alarm_button) ||
          (m_ph == TYPING && alarm_button && m_digits == MAX_DIGITS))
        m_idx <= sel_clip();
      if (next_phase() == IDLE)
        m_digits <= 0;
      else if (m_ph == SHIFTING && m_digits < MAX_DIGITS)
        m_digits <= m_digits + 1;
      if (next_phase() != m_ph || !busy(m_ph))
        m_secs <= 0;
      else if (one_second)
        m_secs <= m_secs + 1;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("m.show_new_time", int'(show_new_time), int'(busy(m_ph) || m_ph == SHIFTING));
    cmp("m.shift",         int'(shift),         int'(m_ph == SHIFTING));
    cmp("m.show_a",        int'(show_a),        int'(m_ph == VIEW_ALARM));
    cmp("m.load_new_c",    int'(load_new_c),    int'(m_ph == COMMIT_TIME));
    cmp("m.reset_count",   int'(reset_count),   int'(m_ph == COMMIT_TIME));
    cmp("m.entry_abort",   int'(entry_abort),   int'(m_ph == DISCARD));
    cmp("m.load_new_a",    int'(load_new_a),    (m_ph == COMMIT_ALARM) ? (1 << m_idx) : 0);
    cmp("m.alarm_idx",     int'(alarm_idx),     m_idx);
    cmp("m.digit_count",   int'(digit_count),   m_digits);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press and release one key; the shift pulse is checked in the cycle after acceptance.
  task automatic press(input logic [3:0] k, input int exp_shift);
    key = k;
    cyc(1);
    cmp("press.shift", int'(shift), exp_shift);
    key = NOKEY;
    cyc(2);
  endtask

  initial begin
    rst = 1'b1; one_second = 1'b0; alarm_button = 1'b0; time_button = 1'b0;
    key = NOKEY; alarm_sel = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    cmp("reset.digit_count", int'(digit_count), 0);
    cmp("reset.show_new_time", int'(show_new_time), 0);

    // 1,2,3,4 then time_button
    press(4'd1, 1); press(4'd2, 1); press(4'd3, 1); press(4'd4, 1);
    cmp("time.digits", int'(digit_count), 4);
    time_button = 1'b1;
    cyc(1);
    cmp("time.load_new_c", int'(load_new_c), 1);
    cmp("time.reset_count", int'(reset_count), 1);
    time_button = 1'b0;
    cyc(1);
    cmp("time.load_off", int'(load_new_c), 0);
    cmp("time.digits_clr", int'(digit_count), 0);
    cyc(1);

    // commit to alarm slot 2
    press(4'd5, 1); press(4'd6, 1); press(4'd7, 1); press(4'd8, 1);
    alarm_sel = 2'd2; alarm_button = 1'b1;
    cyc(1);
    cmp("alarm2.load_new_a", int'(load_new_a), 4);
    cmp("alarm2.idx", int'(alarm_idx), 2);
    alarm_button = 1'b0;
    cyc(1);
    cmp("alarm2.load_off", int'(load_new_a), 0);
    cyc(1);

    // slot 3 with both buttons: alarm wins
    press(4'd0, 1); press(4'd9, 1); press(4'd1, 1); press(4'd2, 1);
    alarm_sel = 2'd3; alarm_button = 1'b1; time_button = 1'b1;
    cyc(1);
    cmp("alarm3.load_new_a", int'(load_new_a), 8);
    cmp("alarm3.load_new_c", int'(load_new_c), 0);
    alarm_button = 1'b0; time_button = 1'b0;
    cyc(2);

    // incomplete entry committed to alarm -> abort
    press(4'd1, 1); press(4'd2, 1);
    alarm_button = 1'b1;
    cyc(1);
    cmp("short.entry_abort", int'(entry_abort), 1);
    cmp("short.load_new_a", int'(load_new_a), 0);
    alarm_button = 1'b0;
    cyc(1);
    cmp("short.abort_off", int'(entry_abort), 0);
    cyc(1);

    // fifth key ignored
    press(4'd1, 1); press(4'd2, 1); press(4'd3, 1); press(4'd4, 1);
    key = 4'd5;
    cyc(1);
    cmp("fifth.shift", int'(shift), 0);
    key = NOKEY;
    cyc(1);
    cmp("fifth.digits", int'(digit_count), 4);
    time_button = 1'b1;
    cyc(1);
    time_button = 1'b0;
    cyc(2);

    // inactivity timeout in entry
    press(4'd3, 1);
    for (int i = 0; i < 3; i++) begin
      one_second = 1'b1;
      cyc(1);
      one_second = 1'b0;
      cyc(1);
      cmp("idle.entry_abort", int'(entry_abort), (i == 2) ? 1 : 0);
    end
    cyc(1);
    cmp("idle.back_home", int'(show_new_time), 0);
    cmp("idle.digits", int'(digit_count), 0);
    cyc(1);

    // key held; pulse on the entry edge into KEY_WAITED is not counted
    key = 4'd7;
    cyc(1);
    one_second = 1'b1;
    cyc(1);
    one_second = 1'b0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      one_second = 1'b1;
      cyc(1);
      one_second = 1'b0;
      cyc(1);
      cmp("held.entry_abort", int'(entry_abort), (i == 2) ? 1 : 0);
    end
    key = NOKEY;
    cyc(2);

    // show alarm; alarm_idx only latched on entry
    alarm_sel = 2'd1; alarm_button = 1'b1;
    cyc(1);
    cmp("view.show_a", int'(show_a), 1);
    cmp("view.idx", int'(alarm_idx), 1);
    alarm_sel = 2'd3;
    cyc(2);
    cmp("view.idx_held", int'(alarm_idx), 1);
    alarm_button = 1'b0;
    cyc(1);
    cmp("view.release", int'(show_a), 0);
    cyc(1);

    // reset mid-entry with two digits
    press(4'd3, 1); press(4'd4, 1);
    cmp("rst.pre_digits", int'(digit_count), 2);
    #2 rst = 1'b1;
    #1;
    cmp("rst.digits", int'(digit_count), 0);
    cmp("rst.show_new_time", int'(show_new_time), 0);
    cmp("rst.abort", int'(entry_abort), 0);
    cmp("rst.load_new_c", int'(load_new_c), 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    cmp("rst.after", int'(show_new_time), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
